// File: rtl/fkey_dec.sv
// Decodes 32-bit ordered integer keys back to IEEE-754 single-precision words; 2-cycle latency.
// Valid/ready on both sides; each stage advances when empty or draining, so it streams at full rate.
module fkey_dec #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_key,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_zero,
  output logic             out_nan,
  output logic             out_bad,
  output logic [CNT_W-1:0] done_cnt
);

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        nan;
    logic        bad;
  } res_t;

  logic        s1_full;
  logic [31:0] s1_key;
  logic        s2_full;
  res_t        s2_res;
  res_t        dec;
  logic        s2_take;
  logic        in_fire;
  logic        out_fire;

  // S2 can take a new entry when it is empty or its current one leaves this cycle.
  assign s2_take  = !s2_full || out_ready;
  assign in_ready = !s1_full || s2_take;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_full && out_ready;

  always_comb begin
    dec      = '0;
    dec.bad  = (s1_key == 32'h7FFF_FFFF);
    if (s1_key[31]) begin
      dec.data = {1'b0, s1_key[30:0]};
    end else begin
      dec.data = {1'b1, ~s1_key[30:0]};
    end
    dec.zero = (dec.data[30:0] == 31'd0);
    dec.nan  = (&dec.data[30:23]) && (|dec.data[22:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full  <= 1'b0;
      s1_key   <= '0;
      s2_full  <= 1'b0;
      s2_res   <= '0;
      done_cnt <= '0;
    end else begin
      if (in_ready) begin
        s1_full <= in_valid;
      end
      if (in_fire) begin
        s1_key <= in_key;
      end
      if (s2_take) begin
        s2_full <= s1_full;
      end
      // Result registers only change on a load so a stalled output stays put.
      if (s2_take && s1_full) begin
        s2_res <= dec;
      end
      if (out_fire) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_full;
  assign out_data  = s2_res.data;
  assign out_zero  = s2_res.zero;
  assign out_nan   = s2_res.nan;
  assign out_bad   = s2_res.bad;

endmodule

// File: doc/fkey_dec.md
FKEY_DEC -- requirements
Module: fkey_dec

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the completed-output counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  an ordered key is present on in_key.
REQ-005 SHALL have port in_key  input  32  ordered integer key to decode.
REQ-006 SHALL have port in_ready  output  1  the block accepts in_key this cycle.
REQ-007 SHALL have port out_valid  output  1  out_* fields hold a decoded result.
REQ-008 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-009 SHALL have port out_data  output  32  IEEE-754 single-precision value.
REQ-010 SHALL have port out_zero  output  1  out_data is +0 or -0.
REQ-011 SHALL have port out_nan  output  1  exponent of out_data is 0xFF and its mantissa is nonzero.
REQ-012 SHALL have port out_bad  output  1  in_key was non-canonical (see REQ-017).
REQ-013 SHALL have port done_cnt  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-014 SHALL invert the float-to-key ordering map, defined as:
- em == 0 -> key 0x80000000
- sign 0 -> key {1, em}
- sign 1 -> key {0, ~em}
REQ-015 SHALL decode key[31]=1 with key[30:0]=0 to out_data 0x00000000, with out_zero=1.
REQ-016 SHALL decode key[31]=1 with key[30:0]!=0 to out_data {0, key[30:0]}.
REQ-017 SHALL decode key[31]=0 to out_data {1, ~key[30:0]}, with one exception:
- key 0x7FFFFFFF decodes to 0x80000000 with out_zero=1 and out_bad=1.
- out_bad=0 for every other key.
REQ-018 SHALL be a two-stage pipeline:
- S1 registers the key.
- S2 registers the decoded word and its flags.
- Latency from accept to out_valid is exactly 2 cycles when no stall occurs.
REQ-019 SHALL treat a transfer as occurring only on a cycle where both valid and ready are 1, on each side.
REQ-020 SHALL advance each stage when that stage is empty or its downstream stage advances in the same cycle.
REQ-021 SHALL drive in_ready = !S1_full || (!S2_full || out_ready), combinationally from state and out_ready only.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-023 SHALL hold out_data, out_zero, out_nan and out_bad stable while out_valid=1 and out_ready=0.
REQ-024 SHALL never drop, duplicate or reorder keys; with both stages full and out_ready=0, in_ready=0.
REQ-025 SHALL, when an accept and an output consume happen in the same cycle, keep the occupancy of each stage consistent with no bubble inserted.
REQ-026 SHALL increment done_cnt by 1 on each output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-027 SHALL ignore in_key when in_valid=0, and SHALL ignore out_ready when out_valid=0.

Reset
REQ-028 SHALL, on a clock edge with rst=1, empty both stages and drive out_valid=0, out_data=0, out_zero=0, out_nan=0, out_bad=0 and done_cnt=0.
REQ-029 SHALL, on rst during operation, discard in-flight keys without emitting them, and SHALL NOT count any transfer in the reset cycle.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst is released.

Verification
REQ-031 Single key: in_key 0x3F800000 (key of -0x3F800000's complement not applicable) accepted with out_ready=1 -> out_data 0xC07FFFFF, out_valid exactly 2 cycles after accept; key 0xBF800000 -> out_data 0x3F800000.
REQ-032 Zeros and bad key:
- 0x80000000 -> out_data 0x00000000, out_zero=1.
- 0x7FFFFFFF -> out_data 0x80000000, out_zero=1, out_bad=1.
- 0xFFC00000 -> out_data 0x7FC00000, out_nan=1.
REQ-033 Back-pressure: stream 8 keys with out_ready held 0 for 5 cycles.
- in_ready falls after 2 accepts.
- All 8 results arrive in order, unchanged while stalled.
- done_cnt=8.
REQ-034 Throughput: 100 random keys with out_ready=1 and in_valid=1 -> one result per cycle; each out_data re-encoded via REQ-014 equals its key (except 0x7FFFFFFF).
REQ-035 Wrap: CNT_W=4, 17 transfers -> done_cnt=1.
REQ-036 Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, done_cnt=0, in_ready=1; the next key has 2-cycle latency.
